// File: rtl/des_region_sequencer_pkg.sv
// Shared definitions for the DES region sequencer: command codes, FSM state
// encodings and result status values.
package des_region_sequencer_pkg;

   localparam logic [31:0] CMD_SEED    = 32'h1;
   localparam logic [31:0] CMD_POLY    = 32'h2;
   localparam logic [31:0] CMD_START   = 32'h3;
   localparam logic [31:0] CMD_RESTART = 32'h5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_POLY,
      ST_SEED,
      ST_START,
      ST_WAIT_DONE,
      ST_CAPTURE,
      ST_RESTART,
      ST_RESULT
   } state_e;

   typedef enum logic [1:0] {
      STATUS_OK      = 2'd0,
      STATUS_ABORTED = 2'd1,
      STATUS_TIMEOUT = 2'd2
   } status_e;

   typedef enum logic [1:0] {
      HS_IDLE,
      HS_VALID,
      HS_RELEASE
   } hs_state_e;

endpackage

// File: rtl/des_region_sequencer_if.sv
// Command bus between the region sequencer (master) and the DES block
// wrapper (slave).
interface des_region_sequencer_if;

   logic [31:0] cmd;
   logic        cmd_valid;
   logic [31:0] data_upper;
   logic [31:0] data_lower;
   logic        cmd_read;
   logic        blk_done;
   logic [63:0] blk_counter;

   modport master (
      output cmd, cmd_valid, data_upper, data_lower,
      input  cmd_read, blk_done, blk_counter
   );

   modport slave (
      input  cmd, cmd_valid, data_upper, data_lower,
      output cmd_read, blk_done, blk_counter
   );

endinterface

// File: rtl/des_region_sequencer_cmd_handshake.sv
// Four-phase command handshake with the wrapper: raise cmd_valid, wait for
// cmd_read, drop cmd_valid, wait for cmd_read to clear. Each phase is bounded.
module des_cmd_handshake
   import des_region_sequencer_pkg::*;
#(
   parameter int HS_TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic issue,
   input  logic cmd_read,
   output logic cmd_valid,
   output logic done,
   output logic timeout
);

   localparam int             CW       = (HS_TIMEOUT > 1) ? $clog2(HS_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(HS_TIMEOUT - 1);

   hs_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= HS_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // cnt_q counts cycles spent in the current phase; it restarts on every phase change
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done    = 1'b0;
      timeout = 1'b0;
      case (state_q)
         HS_VALID: begin
            if (cmd_read) begin
               state_d = HS_RELEASE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HS_IDLE;
               timeout = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         HS_RELEASE: begin
            if (!cmd_read) begin
               state_d = HS_IDLE;
               done    = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HS_IDLE;
               timeout = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: ;
      endcase
      if (issue) begin
         state_d = HS_VALID;
         cnt_d   = '0;
      end
   end

   assign cmd_valid = (state_q == HS_VALID);

endmodule

// File: rtl/des_region_sequencer.sv
// Walks a job through its regions on the DES wrapper: program the polynomial
// once, then seed/start/wait/capture/restart per region and report statistics.
module des_region_sequencer
   import des_region_sequencer_pkg::*;
#(
   parameter logic [63:0] SEED_STEP  = 64'h0000_0001_0000_0000,
   parameter int          HS_TIMEOUT = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          job_valid,
   output logic                          job_ready,
   input  logic [63:0]                   job_seed,
   input  logic [63:0]                   job_poly,
   input  logic [15:0]                   job_regions,
   input  logic                          abort,
   des_region_sequencer_if.master        bus,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [79:0]                   res_total,
   output logic [63:0]                   res_max,
   output logic [15:0]                   res_max_idx,
   output logic [1:0]                    res_status,
   output logic                          busy
);

   state_e      state_q, state_d;
   status_e     status_q, status_d;
   logic [63:0] seed_q, seed_d;
   logic [15:0] regions_q, regions_d;
   logic [15:0] idx_q, idx_d;
   logic [79:0] total_q, total_d;
   logic [63:0] max_q, max_d;
   logic [15:0] max_idx_q, max_idx_d;
   logic        abort_pend_q, abort_pend_d;
   logic [31:0] cmd_q, cmd_d;
   logic [63:0] data_q, data_d;

   logic        hs_issue, hs_done, hs_timeout, hs_cmd_valid;
   logic        abort_now;
   logic [15:0] idx_next;
   logic [63:0] seed_next;

   des_cmd_handshake #(
      .HS_TIMEOUT (HS_TIMEOUT)
   ) u_handshake (
      .clk       (clk),
      .rst_n     (rst_n),
      .issue     (hs_issue),
      .cmd_read  (bus.cmd_read),
      .cmd_valid (hs_cmd_valid),
      .done      (hs_done),
      .timeout   (hs_timeout)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         status_q     <= STATUS_OK;
         seed_q       <= '0;
         regions_q    <= '0;
         idx_q        <= '0;
         total_q      <= '0;
         max_q        <= '0;
         max_idx_q    <= '0;
         abort_pend_q <= 1'b0;
         cmd_q        <= '0;
         data_q       <= '0;
      end else begin
         state_q      <= state_d;
         status_q     <= status_d;
         seed_q       <= seed_d;
         regions_q    <= regions_d;
         idx_q        <= idx_d;
         total_q      <= total_d;
         max_q        <= max_d;
         max_idx_q    <= max_idx_d;
         abort_pend_q <= abort_pend_d;
         cmd_q        <= cmd_d;
         data_q       <= data_d;
      end
   end

   assign abort_now = abort_pend_q | abort;
   assign idx_next  = idx_q + 16'd1;
   assign seed_next = seed_q + SEED_STEP;

   // cmd_q/data_q only load together with hs_issue, which keeps them frozen for the whole handshake
   always_comb begin
      state_d      = state_q;
      status_d     = status_q;
      seed_d       = seed_q;
      regions_d    = regions_q;
      idx_d        = idx_q;
      total_d      = total_q;
      max_d        = max_q;
      max_idx_d    = max_idx_q;
      abort_pend_d = abort_pend_q;
      cmd_d        = cmd_q;
      data_d       = data_q;
      hs_issue     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (job_valid) begin
               seed_d       = job_seed;
               regions_d    = job_regions;
               idx_d        = '0;
               total_d      = '0;
               max_d        = '0;
               max_idx_d    = '0;
               status_d     = STATUS_OK;
               abort_pend_d = 1'b0;
               if (job_regions == 16'd0) begin
                  state_d = ST_RESULT;
               end else begin
                  state_d  = ST_POLY;
                  hs_issue = 1'b1;
                  cmd_d    = CMD_POLY;
                  data_d   = job_poly;
               end
            end
         end
         ST_POLY: begin
            if (hs_timeout) begin
               state_d  = ST_RESULT;
               status_d = STATUS_TIMEOUT;
            end else if (hs_done) begin
               state_d  = ST_SEED;
               hs_issue = 1'b1;
               cmd_d    = CMD_SEED;
               data_d   = seed_q;
            end
         end
         ST_SEED, ST_START: begin
            abort_pend_d = abort_now;
            if (hs_timeout) begin
               state_d  = ST_RESULT;
               status_d = STATUS_TIMEOUT;
            end else if (hs_done) begin
               if (abort_now) begin
                  state_d  = ST_RESTART;
                  hs_issue = 1'b1;
                  cmd_d    = CMD_RESTART;
                  data_d   = '0;
               end else if (state_q == ST_SEED) begin
                  state_d  = ST_START;
                  hs_issue = 1'b1;
                  cmd_d    = CMD_START;
                  data_d   = '0;
               end else begin
                  state_d = ST_WAIT_DONE;
               end
            end
         end
         ST_WAIT_DONE: begin
            if (bus.blk_done) begin
               state_d = ST_CAPTURE;
            end else if (abort) begin
               abort_pend_d = 1'b1;
               state_d      = ST_RESTART;
               hs_issue     = 1'b1;
               cmd_d        = CMD_RESTART;
               data_d       = '0;
            end
         end
         ST_CAPTURE: begin
            total_d = total_q + {16'd0, bus.blk_counter};
            if (bus.blk_counter > max_q) begin
               max_d     = bus.blk_counter;
               max_idx_d = idx_q;
            end
            state_d  = ST_RESTART;
            hs_issue = 1'b1;
            cmd_d    = CMD_RESTART;
            data_d   = '0;
         end
         ST_RESTART: begin
            if (hs_timeout) begin
               state_d  = ST_RESULT;
               status_d = STATUS_TIMEOUT;
            end else if (hs_done) begin
               if (abort_pend_q) begin
                  state_d  = ST_RESULT;
                  status_d = STATUS_ABORTED;
               end else begin
                  idx_d  = idx_next;
                  seed_d = seed_next;
                  if (idx_next == regions_q) begin
                     state_d = ST_RESULT;
                  end else begin
                     state_d  = ST_SEED;
                     hs_issue = 1'b1;
                     cmd_d    = CMD_SEED;
                     data_d   = seed_next;
                  end
               end
            end
         end
         ST_RESULT: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign job_ready      = (state_q == ST_IDLE);
   assign busy           = (state_q != ST_IDLE);
   assign res_valid      = (state_q == ST_RESULT);
   assign res_total      = total_q;
   assign res_max        = max_q;
   assign res_max_idx    = max_idx_q;
   assign res_status     = status_q;
   assign bus.cmd        = cmd_q;
   assign bus.cmd_valid  = hs_cmd_valid;
   assign bus.data_upper = data_q[63:32];
   assign bus.data_lower = data_q[31:0];

endmodule
